// File: rtl/alu_op_sequencer_if.sv
// Command and response channels between a requester and alu_op_sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic [CNT_W-1:0] cmd_count;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cout;

  // Requester side: issues commands, consumes responses
  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_count,
    input  cmd_ready,
    input  rsp_valid, rsp_f, rsp_cout,
    output rsp_ready
  );

  // Sequencer side: accepts commands, produces responses
  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_count,
    output cmd_ready,
    output rsp_valid, rsp_f, rsp_cout,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational 32-bit ALU from registered operands, one command at a
// time, and returns F/Cout on a valid/ready response channel. Multi-bit shifts
// are built by re-feeding the ALU's single-position shift result into operand A.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             op_cin;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] rsp_f_q;
  logic             rsp_cout_q;
  logic             rsp_valid_q;
  logic             cmd_ready_q;
  logic             busy_q;

  // Every output comes straight from a register; no input reaches an output
  // combinationally.
  assign alu_a         = op_a;
  assign alu_b         = op_b;
  assign alu_sel       = op_sel;
  assign alu_cin       = op_cin;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign busy          = busy_q;

  // Control FSM with registered operand, handshake and result outputs.
  // cmd_ready is a register rather than a state decode so that it reads 0
  // while reset is held and rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_sel      <= '0;
      op_cin      <= 1'b0;
      remaining   <= '0;
      rsp_f_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_a        <= bus.cmd_a;
            op_b        <= bus.cmd_b;
            op_sel      <= bus.cmd_sel;
            op_cin      <= bus.cmd_cin;
            remaining   <= bus.cmd_count;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= EXEC;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        EXEC: begin
          if (!op_sel[3]) begin
            // Arith/logic: single pass; carry only meaningful for arith
            rsp_f_q     <= alu_f;
            rsp_cout_q  <= (op_sel[3:2] == 2'b00) ? alu_cout : 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (remaining == '0) begin
            // Zero-count shift returns operand A untouched
            rsp_f_q     <= op_a;
            rsp_cout_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            op_a      <= alu_f;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              rsp_f_q     <= alu_f;
              rsp_cout_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
